// File: rtl/d_cache_port_arbiter.sv
// d_cache_port_arbiter
//   Arbitrates between the load pipe and the committed-store buffer for the
//   single d-cache port. It also owns the issue register that feeds the cache.
//   A cache miss freezes the issue register. A flush turns a held load into a
//   nop, but the access stays valid so that an in-flight miss still completes.
//
// Optional feature macro: D_CACHE_ARB_STARVE_EN
//   When defined, a starvation counter promotes a waiting store. The store
//   takes priority after STARVE_LIMIT consecutive cycles in which it lost to
//   a load. When undefined, loads always have strict priority.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   ld_valid/ld_ready        load request handshake (ready is combinational)
//   ld_addr, ld_id           load address and active-list id
//   st_valid/st_ready        committed-store handshake (ready is combinational)
//   st_addr, st_data         store address and data
//   dc_miss                  cache miss; freezes the issue register, blocks grants
//   flush                    misprediction recovery; squashes speculative loads
//   o_valid, o_mem_action    issue register valid, action (0=READ, 1=WRITE)
//   o_nop                    issue register squashed / empty marker
//   o_addr, o_data, o_id     issue register payload
//   o_addr_next              combinational next address for SRAM indexing
//   o_state                  FSM state: 0=IDLE, 1=BUSY, 2=MISS
module d_cache_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [ID_WIDTH-1:0]   ld_id,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  dc_miss,
  input  logic                  flush,
  output logic                  o_valid,
  output logic                  o_mem_action,
  output logic                  o_nop,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic [ADDR_WIDTH-1:0] o_addr_next,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_MISS = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    ld_cand_s;
  logic                    promote_s;
  logic                    ld_grant_s;
  logic                    st_grant_s;
  logic                    valid_r;
  logic                    action_r;
  logic                    nop_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [ID_WIDTH-1:0]     id_r;

  // A flushed load is speculative and must not be issued this cycle.
  assign ld_cand_s = ld_valid & ~flush;

`ifdef D_CACHE_ARB_STARVE_EN
  logic [3:0] starve_cnt_r;

  assign promote_s = (starve_cnt_r == 4'(STARVE_LIMIT));

  // Starvation counter: counts cycles a waiting store lost to a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (st_grant_s) begin
      starve_cnt_r <= 4'd0;
    end else if (st_valid && ld_grant_s && (starve_cnt_r != 4'(STARVE_LIMIT))) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // Strict load priority: the limit is accepted but has no effect.
  logic [3:0] limit_unused_s;
  assign limit_unused_s = 4'(STARVE_LIMIT);
  assign promote_s      = 1'b0;
`endif

  // Grant selection: a load wins by default. A store wins when no load is
  // eligible, or when the store has been promoted by the starvation counter.
  always_comb begin
    ld_grant_s = 1'b0;
    st_grant_s = 1'b0;
    if (rst || dc_miss) begin
      ld_grant_s = 1'b0;
      st_grant_s = 1'b0;
    end else if (st_valid && (promote_s || !ld_cand_s)) begin
      st_grant_s = 1'b1;
    end else if (ld_cand_s) begin
      ld_grant_s = 1'b1;
    end else begin
      ld_grant_s = 1'b0;
      st_grant_s = 1'b0;
    end
  end

  assign ld_ready = ld_grant_s;
  assign st_ready = st_grant_s;

  // Next SRAM index: hold during a miss, otherwise follow the winner.
  always_comb begin
    o_addr_next = addr_r;
    if (dc_miss) begin
      o_addr_next = addr_r;
    end else if (ld_grant_s) begin
      o_addr_next = ld_addr;
    end else if (st_grant_s) begin
      o_addr_next = st_addr;
    end else begin
      o_addr_next = addr_r;
    end
  end

  // Issue register: loads on a grant and freezes during a miss. A flush only
  // marks a held load as a nop, so that its outstanding miss still drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      action_r <= 1'b0;
      nop_r    <= 1'b1;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      data_r   <= {DATA_WIDTH{1'b0}};
      id_r     <= {ID_WIDTH{1'b0}};
    end else if (!dc_miss) begin
      if (ld_grant_s) begin
        valid_r  <= 1'b1;
        action_r <= 1'b0;
        nop_r    <= 1'b0;
        addr_r   <= ld_addr;
        data_r   <= {DATA_WIDTH{1'b0}};
        id_r     <= ld_id;
      end else if (st_grant_s) begin
        valid_r  <= 1'b1;
        action_r <= 1'b1;
        nop_r    <= 1'b0;
        addr_r   <= st_addr;
        data_r   <= st_data;
        id_r     <= {ID_WIDTH{1'b0}};
      end else begin
        valid_r  <= 1'b0;
        nop_r    <= 1'b1;
      end
    end else if (flush && valid_r && !action_r) begin
      nop_r <= 1'b1;
    end else begin
      nop_r <= nop_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state. A miss in IDLE has no access behind it and is ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_grant_s || st_grant_s) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY, ST_MISS: begin
        if (dc_miss) begin
          state_next_s = ST_MISS;
        end else if (ld_grant_s || st_grant_s) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign o_valid      = valid_r;
  assign o_mem_action = action_r;
  assign o_nop        = nop_r;
  assign o_addr       = addr_r;
  assign o_data       = data_r;
  assign o_id         = id_r;
  assign o_state      = state_r;

endmodule

// File: tb/tb_d_cache_port_arbiter.sv
// Directed testbench for d_cache_port_arbiter. Inputs are driven 1ns after
// the rising edge. Combinational outputs are checked 1ns after that.
// Registered outputs are checked 1ns after the following rising edge.
module tb_d_cache_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [3:0]  ld_id;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        dc_miss;
  logic        flush;
  logic        o_valid;
  logic        o_mem_action;
  logic        o_nop;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic [3:0]  o_id;
  logic [31:0] o_addr_next;
  logic [1:0]  o_state;

  int n_vec  = 0;
  int n_fail = 0;

  d_cache_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_id(ld_id),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .dc_miss(dc_miss), .flush(flush),
    .o_valid(o_valid), .o_mem_action(o_mem_action), .o_nop(o_nop),
    .o_addr(o_addr), .o_data(o_data), .o_id(o_id),
    .o_addr_next(o_addr_next), .o_state(o_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle_inputs;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_id = 4'h0;
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
    dc_miss = 1'b0; flush = 1'b0;
  endtask

  task do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task test_reset;
    idle_inputs();
    rst = 1'b1; ld_valid = 1'b1; st_valid = 1'b1; dc_miss = 1'b1; flush = 1'b1;
    #1;
    n_vec++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
    n_vec++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL rst_st_ready: got %b want 0", st_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    n_vec++; if (o_nop !== 1'b1) begin n_fail++; $display("FAIL rst_nop: got %b want 1", o_nop); end
    n_vec++; if ({o_mem_action, o_addr, o_data, o_id} !== 69'h0) begin n_fail++; $display("FAIL rst_payload: got %h want 0", {o_mem_action, o_addr, o_data, o_id}); end
    n_vec++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", o_state); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task test_load_issue;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h100; ld_id = 4'd3;
    #1;
    n_vec++; if (ld_ready !== 1'b1 || st_ready !== 1'b0) begin n_fail++; $display("FAIL ld_ready: got %b%b want 10", ld_ready, st_ready); end
    n_vec++; if (o_addr_next !== 32'h100) begin n_fail++; $display("FAIL ld_addr_next: got %h want 100", o_addr_next); end
    tick();
    ld_valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1 || o_mem_action !== 1'b0 || o_nop !== 1'b0) begin n_fail++; $display("FAIL ld_issue_ctl: got v%b a%b n%b want v1 a0 n0", o_valid, o_mem_action, o_nop); end
    n_vec++; if (o_addr !== 32'h100 || o_id !== 4'd3 || o_data !== 32'h0) begin n_fail++; $display("FAIL ld_issue_payload: got %h/%h/%h want 100/3/0", o_addr, o_id, o_data); end
    n_vec++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL ld_state: got %0d want 1", o_state); end
    tick();
    n_vec++; if (o_valid !== 1'b0 || o_nop !== 1'b1 || o_addr !== 32'h100) begin n_fail++; $display("FAIL ld_idle_hold: got v%b n%b a%h want v0 n1 a100", o_valid, o_nop, o_addr); end
    n_vec++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL ld_back_idle: got %0d want 0", o_state); end
  endtask

  task test_store_issue;
    do_reset();
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hDEADBEEF;
    #1;
    n_vec++; if (st_ready !== 1'b1 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready: got %b%b want 01", ld_ready, st_ready); end
    tick();
    st_valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1 || o_mem_action !== 1'b1 || o_nop !== 1'b0) begin n_fail++; $display("FAIL st_issue_ctl: got v%b a%b n%b want v1 a1 n0", o_valid, o_mem_action, o_nop); end
    n_vec++; if (o_addr !== 32'h300 || o_data !== 32'hDEADBEEF || o_id !== 4'd0) begin n_fail++; $display("FAIL st_issue_payload: got %h/%h/%h want 300/deadbeef/0", o_addr, o_data, o_id); end
  endtask

  task test_starvation;
    logic exp_st;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h440; ld_id = 4'd2;
    st_valid = 1'b1; st_addr = 32'h880; st_data = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
`ifdef D_CACHE_ARB_STARVE_EN
      exp_st = ((i % 5) == 4);
`else
      exp_st = 1'b0;
`endif
      #1;
      n_vec++; if (st_ready !== exp_st || ld_ready !== !exp_st) begin n_fail++; $display("FAIL starve_grant[%0d]: got ld%b st%b want st%b", i, ld_ready, st_ready, exp_st); end
      tick();
      n_vec++; if (o_mem_action !== exp_st || o_valid !== 1'b1) begin n_fail++; $display("FAIL starve_issue[%0d]: got a%b v%b want a%b v1", i, o_mem_action, o_valid, exp_st); end
`ifdef D_CACHE_ARB_STARVE_EN
      if (exp_st) begin
        n_vec++; if (dut.starve_cnt_r !== 4'd0) begin n_fail++; $display("FAIL starve_cnt_clear[%0d]: got %0d want 0", i, dut.starve_cnt_r); end
      end
`endif
    end
`ifdef D_CACHE_ARB_STARVE_EN
    // Four more load wins bring the counter back to the limit; a flush must
    // not stop the promoted store.
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    #1;
    n_vec++; if (st_ready !== 1'b1 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL starve_flush: got ld%b st%b want ld0 st1", ld_ready, st_ready); end
    flush = 1'b0;
`endif
    idle_inputs();
  endtask

  task test_miss;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h200; ld_id = 4'd5;
    tick();
    ld_valid = 1'b1; ld_addr = 32'h999; ld_id = 4'd9;
    st_valid = 1'b1; st_addr = 32'h777; dc_miss = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (ld_ready !== 1'b0 || st_ready !== 1'b0) begin n_fail++; $display("FAIL miss_ready[%0d]: got %b%b want 00", i, ld_ready, st_ready); end
      n_vec++; if (o_addr_next !== 32'h200) begin n_fail++; $display("FAIL miss_addr_next[%0d]: got %h want 200", i, o_addr_next); end
      tick();
      n_vec++; if (o_state !== 2'd2 || o_valid !== 1'b1 || o_addr !== 32'h200 || o_id !== 4'd5 || o_nop !== 1'b0) begin n_fail++; $display("FAIL miss_frozen[%0d]: got s%0d v%b a%h id%h n%b want s2 v1 a200 id5 n0", i, o_state, o_valid, o_addr, o_id, o_nop); end
    end
    dc_miss = 1'b0; st_valid = 1'b0; ld_addr = 32'h204; ld_id = 4'd6;
    #1;
    n_vec++; if (ld_ready !== 1'b1 || o_addr_next !== 32'h204) begin n_fail++; $display("FAIL miss_release: got rdy%b next%h want rdy1 next204", ld_ready, o_addr_next); end
    tick();
    n_vec++; if (o_state !== 2'd1 || o_addr !== 32'h204 || o_id !== 4'd6) begin n_fail++; $display("FAIL miss_regrant: got s%0d a%h id%h want s1 a204 id6", o_state, o_addr, o_id); end
    idle_inputs();
  endtask

  task test_flush_miss;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h400; ld_id = 4'd7;
    tick();
    ld_valid = 1'b0; dc_miss = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (o_nop !== 1'b1 || o_valid !== 1'b1 || o_addr !== 32'h400 || o_mem_action !== 1'b0) begin n_fail++; $display("FAIL flush_ld_miss: got n%b v%b a%h act%b want n1 v1 a400 act0", o_nop, o_valid, o_addr, o_mem_action); end
    tick();
    n_vec++; if (o_nop !== 1'b1 || o_state !== 2'd2) begin n_fail++; $display("FAIL flush_ld_hold: got n%b s%0d want n1 s2", o_nop, o_state); end
    do_reset();
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'hA5A5A5A5;
    tick();
    st_valid = 1'b0; dc_miss = 1'b1; flush = 1'b1;
    tick();
    tick();
    n_vec++; if (o_nop !== 1'b0 || o_valid !== 1'b1 || o_mem_action !== 1'b1 || o_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL flush_st_miss: got n%b v%b act%b d%h want n0 v1 act1 da5a5a5a5", o_nop, o_valid, o_mem_action, o_data); end
    idle_inputs();
  endtask

  task test_flush_grant;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h10; ld_id = 4'd1;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h55;
    flush = 1'b1;
    #1;
    n_vec++; if (st_ready !== 1'b1 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL flush_grant: got ld%b st%b want ld0 st1", ld_ready, st_ready); end
    n_vec++; if (o_addr_next !== 32'h20) begin n_fail++; $display("FAIL flush_addr_next: got %h want 20", o_addr_next); end
    tick();
    st_valid = 1'b0;
    n_vec++; if (o_mem_action !== 1'b1 || o_addr !== 32'h20) begin n_fail++; $display("FAIL flush_issue: got act%b a%h want act1 a20", o_mem_action, o_addr); end
    #1;
    n_vec++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ld_only: got %b want 0", ld_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b0 || o_nop !== 1'b1) begin n_fail++; $display("FAIL flush_no_issue: got v%b n%b want v0 n1", o_valid, o_nop); end
    idle_inputs();
  endtask

  task test_idle_miss;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h44; dc_miss = 1'b1;
    #1;
    n_vec++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL idle_miss_ready: got %b want 0", ld_ready); end
    tick();
    n_vec++; if (o_state !== 2'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_miss_state: got s%0d v%b want s0 v0", o_state, o_valid); end
    idle_inputs();
  endtask

  task test_reset_mid_miss;
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h500; ld_id = 4'd4;
    st_valid = 1'b1; st_addr = 32'h510;
    tick();
    tick();
    ld_valid = 1'b0; st_valid = 1'b0; dc_miss = 1'b1;
    tick();
    n_vec++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL rmiss_pre_state: got %0d want 2", o_state); end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (o_valid !== 1'b0 || o_nop !== 1'b1 || o_state !== 2'd0 || o_addr !== 32'h0) begin n_fail++; $display("FAIL rmiss_reset: got v%b n%b s%0d a%h want v0 n1 s0 a0", o_valid, o_nop, o_state, o_addr); end
`ifdef D_CACHE_ARB_STARVE_EN
    n_vec++; if (dut.starve_cnt_r !== 4'd0) begin n_fail++; $display("FAIL rmiss_cnt: got %0d want 0", dut.starve_cnt_r); end
`endif
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_load_issue();
    test_store_issue();
    test_starvation();
    test_miss();
    test_flush_miss();
    test_flush_grant();
    test_idle_miss();
    test_reset_mid_miss();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
